// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//
// Shares the core's single AHB-Lite master port between the instruction
// fetch requester (IF, read-only) and the load/store requester (MEM).
// Each granted request is carried through one AHB address phase and one
// data phase. Only one transfer is in flight at a time. The completion
// result is held in a per-requester register until the pipeline advances.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   if_req/if_addr  fetch request (held stable while ahb_bus_wait=1)
//   if_rdata/if_err latched fetch data and error
//   mem_req/mem_we/mem_addr/mem_size/mem_wdata
//                   load/store request (held stable while ahb_bus_wait=1)
//   mem_rdata/mem_err latched load data and load/store error
//   ahb_bus_wait    combinational stall request to cpu_ctrl
//   haddr/htrans/hwrite/hsize/hwdata   registered AHB master outputs
//   hrdata/hready/hresp                AHB slave responses
//
// Parameters
//   ADDR_WIDTH  width of request addresses and HADDR
//   DATA_WIDTH  width of read/write data
//   RR_ARB      0 = fixed priority (MEM wins), 1 = round-robin on last grant

module ahb_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_ARB     = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,

    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err,

    output logic                  ahb_bus_wait,

    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Instruction fetches are always full words.
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    logic [1:0] state;

    // Owner of the transfer in flight: 1 = MEM, 0 = IF.
    logic       owner_mem;

    // Owner of the most recent grant, same encoding as owner_mem. Reset
    // to IF, so the first tie under round-robin goes to MEM.
    logic       last_grant;

    logic       if_rvalid;
    logic       mem_rvalid;

    logic       if_pend;
    logic       mem_pend;
    logic       grant_mem;

    // A requester stays pending until its result has been delivered.
    // The stall is combinational, so a new request stalls the pipeline in
    // the same cycle it appears.
    assign if_pend      = if_req  & ~if_rvalid;
    assign mem_pend     = mem_req & ~mem_rvalid;
    assign ahb_bus_wait = if_pend | mem_pend;

    // Grant selection. Used only in IDLE when at least one request is
    // pending. With a single pending requester it always wins. On a tie,
    // fixed priority picks MEM, and round-robin picks whoever was not
    // granted last.
    always_comb begin
        grant_mem = mem_pend;
        if ((RR_ARB != 0) && if_pend && mem_pend) begin
            grant_mem = ~last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner_mem  <= 1'b0;
            last_grant <= 1'b0;
            htrans     <= HTRANS_IDLE;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hsize      <= 3'b000;
            hwdata     <= '0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            if_rvalid  <= 1'b0;
            mem_rdata  <= '0;
            mem_err    <= 1'b0;
            mem_rvalid <= 1'b0;
        end else begin
            // Release: once the pipeline is no longer stalled, the
            // requesters have sampled their results. Clear the valid flags
            // so that the next request becomes pending. A completion in
            // the same cycle, written below, takes precedence.
            if (!ahb_bus_wait) begin
                if_rvalid  <= 1'b0;
                mem_rvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (if_pend || mem_pend) begin
                        htrans     <= HTRANS_NONSEQ;
                        owner_mem  <= grant_mem;
                        last_grant <= grant_mem;
                        if (grant_mem) begin
                            haddr  <= mem_addr;
                            hwrite <= mem_we;
                            hsize  <= {1'b0, mem_size};
                        end else begin
                            haddr  <= if_addr;
                            hwrite <= 1'b0;
                            hsize  <= HSIZE_WORD;
                        end
                        state <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    // Address-phase controls stay on the bus until the
                    // slave accepts them.
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        // hwrite is set only for a MEM store, so it also
                        // selects whether write data is needed.
                        if (owner_mem && hwrite) begin
                            hwdata <= mem_wdata;
                        end
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (hready) begin
                        // An ERROR response finishes like a normal transfer
                        // with the error flag set. Read data from an ERROR
                        // response is not meaningful, so the previous
                        // rdata is kept.
                        if (owner_mem) begin
                            mem_err    <= hresp;
                            mem_rvalid <= 1'b1;
                            if (!hwrite && !hresp) begin
                                mem_rdata <= hrdata;
                            end
                        end else begin
                            if_err    <= hresp;
                            if_rvalid <= 1'b1;
                            if (!hresp) begin
                                if_rdata <= hrdata;
                            end
                        end
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule
